// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared state encoding and default sizes for the wishbone master port
package wb_pkg;

   localparam int WB_ADDR_W  = 16;
   localparam int WB_DATA_W  = 16;
   localparam int WB_TIMEOUT = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - counts unanswered strobe cycles and flags the abort cycle
module wb_timeout_cnt
   import wb_pkg::*;
#(
   parameter int TIMEOUT = WB_TIMEOUT
)(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Asserted in the cycle whose unanswered edge brings the count to TIMEOUT.
   assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/wb_master_port.sv
// rtl/wb_master_port.sv - single-outstanding CPU request to wishbone classic master
module wb_master_port
   import wb_pkg::*;
#(
   parameter int ADDR_W  = WB_ADDR_W,
   parameter int DATA_W  = WB_DATA_W,
   parameter int TIMEOUT = WB_TIMEOUT
)(
   input  logic                clk,
   input  logic                reset,

   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_adr,
   input  logic [DATA_W-1:0]   req_dat,
   input  logic [DATA_W/8-1:0] req_sel,

   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_dat,
   output logic                rsp_err,

   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic                wb_ack_i,
   input  logic                wb_err_i
);

   wb_state_e state;
   logic      timeout_hit;
   logic      bus_done;

   wb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == ST_IDLE),
      .enable  ((state == ST_BUS) && !wb_ack_i && !wb_err_i),
      .expired (timeout_hit)
   );

   assign bus_done = wb_ack_i || wb_err_i || timeout_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
         wb_sel_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state     <= ST_BUS;
                  req_ready <= 1'b0;
                  wb_cyc_o  <= 1'b1;
                  wb_stb_o  <= 1'b1;
                  wb_we_o   <= req_we;
                  wb_adr_o  <= req_adr;
                  wb_dat_o  <= req_dat;
                  wb_sel_o  <= req_sel;
               end
            end
            ST_BUS: begin
               if (bus_done) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  // Error wins over ack; neither present means the timeout fired.
                  rsp_err   <= wb_err_i || !wb_ack_i;
                  rsp_dat   <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : '0;
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  wb_we_o   <= 1'b0;
                  wb_adr_o  <= '0;
                  wb_dat_o  <= '0;
                  wb_sel_o  <= '0;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_dat   <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_dat   <= '0;
               rsp_err   <= 1'b0;
               wb_cyc_o  <= 1'b0;
               wb_stb_o  <= 1'b0;
               wb_we_o   <= 1'b0;
               wb_adr_o  <= '0;
               wb_dat_o  <= '0;
               wb_sel_o  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_port.sv
// tb/tb_wb_master_port.sv - randomized and directed checks of the wishbone master port
module tb_wb_master_port;

   localparam int TO = 15;

   logic        clk;
   logic        reset;

   logic        req_valid, req_ready, req_we;
   logic [15:0] req_adr, req_dat;
   logic [1:0]  req_sel;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [15:0] rsp_dat;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [1:0]  wb_sel_o;
   logic        wb_ack_i, wb_err_i;

   logic        req_valid_w, req_ready_w, req_we_w;
   logic [15:0] req_adr_w;
   logic [31:0] req_dat_w;
   logic [3:0]  req_sel_w;
   logic        rsp_valid_w, rsp_ready_w, rsp_err_w;
   logic [31:0] rsp_dat_w;
   logic        wb_cyc_o_w, wb_stb_o_w, wb_we_o_w;
   logic [15:0] wb_adr_o_w;
   logic [31:0] wb_dat_o_w, wb_dat_i_w;
   logic [3:0]  wb_sel_o_w;
   logic        wb_ack_i_w, wb_err_i_w;

   int checks   = 0;
   int failures = 0;

   wb_master_port #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   wb_master_port #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) u_dut32 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_w), .req_ready(req_ready_w), .req_we(req_we_w),
      .req_adr(req_adr_w), .req_dat(req_dat_w), .req_sel(req_sel_w),
      .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready_w), .rsp_dat(rsp_dat_w), .rsp_err(rsp_err_w),
      .wb_cyc_o(wb_cyc_o_w), .wb_stb_o(wb_stb_o_w), .wb_we_o(wb_we_o_w),
      .wb_adr_o(wb_adr_o_w), .wb_dat_o(wb_dat_o_w), .wb_sel_o(wb_sel_o_w),
      .wb_dat_i(wb_dat_i_w), .wb_ack_i(wb_ack_i_w), .wb_err_i(wb_err_i_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Expected outcome from the protocol rules: reply in strobe cycle 'reply' (0 = never).
   function automatic void ref_model(input logic we, input int reply, input int kind,
                                     input logic [15:0] rdata, output int stb,
                                     output logic err, output logic [15:0] dat);
      bit answered;
      answered = (reply >= 1) && (reply <= TO);
      stb = answered ? reply : TO;
      err = !answered || (kind != 0);
      dat = (err || we) ? 16'h0 : rdata;
   endfunction

   task automatic issue(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel);
      req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
      @(negedge clk);
      req_valid = 1'b0; req_we = $urandom_range(0, 1);
      req_adr = 16'($urandom); req_dat = 16'($urandom); req_sel = 2'($urandom);
   endtask

   // kind: 0 ack, 1 err, 2 ack and err together
   task automatic serve(input int reply, input int kind, input logic [15:0] rdata,
                        input logic we, input logic [15:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel, output int stb_cnt, output int bad);
      stb_cnt = 0;
      bad = 0;
      for (int guard = 0; guard < 64 && wb_cyc_o; guard++) begin
         stb_cnt++;
         if (wb_stb_o !== 1'b1 || wb_we_o !== we || wb_adr_o !== adr ||
             wb_dat_o !== dat || wb_sel_o !== sel || req_ready !== 1'b0) bad++;
         if (stb_cnt == reply) begin
            wb_ack_i = (kind != 1); wb_err_i = (kind != 0); wb_dat_i = rdata;
         end else begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 16'($urandom);
         end
         @(negedge clk);
      end
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
   endtask

   task automatic consume(input int hold, output int unstable);
      logic [15:0] d0;
      logic        e0;
      d0 = rsp_dat;
      e0 = rsp_err;
      unstable = 0;
      rsp_ready = 1'b0;
      repeat (hold) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_dat !== d0 || rsp_err !== e0 ||
             req_ready !== 1'b0 || wb_cyc_o !== 1'b0) unstable++;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      wb_ack_i = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 16'h0) begin
         failures++;
         $display("FAIL reset_rsp got ready=%b valid=%b err=%b dat=%h exp 1 0 0 0000",
                  req_ready, rsp_valid, rsp_err, rsp_dat);
      end
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== 37'h0) begin
         failures++;
         $display("FAIL reset_wb got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b exp all 0",
                  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o);
      end
      wb_err_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
         failures++;
         $display("FAIL idle_ack_ignored got valid=%b ready=%b cyc=%b exp 0 1 0",
                  rsp_valid, req_ready, wb_cyc_o);
      end
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
   endtask

   task automatic test_read_wait;
      int stb, bad, uns;
      logic [15:0] d;
      d = 16'($urandom);
      issue(1'b0, 16'h1234, d, 2'b11);
      serve(2, 0, 16'hBEEF, 1'b0, 16'h1234, d, 2'b11, stb, bad);
      checks++;
      if (stb !== 2 || bad !== 0) begin
         failures++;
         $display("FAIL read_cyc got cycles=%0d bad=%0d exp 2 0", stb, bad);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== 16'hBEEF || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL read_rsp got valid=%b dat=%h err=%b exp 1 beef 0", rsp_valid, rsp_dat, rsp_err);
      end
      checks++;
      if (wb_adr_o !== 16'h0 || wb_sel_o !== 2'b00) begin
         failures++;
         $display("FAIL read_wb_idle got adr=%h sel=%b exp 0000 00", wb_adr_o, wb_sel_o);
      end
      consume(0, uns);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL read_done got valid=%b ready=%b exp 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_write_zero_wait;
      int stb, bad, uns;
      issue(1'b1, 16'h0040, 16'hA5A5, 2'b01);
      checks++;
      if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 || wb_dat_o !== 16'hA5A5 || wb_sel_o !== 2'b01) begin
         failures++;
         $display("FAIL write_wb got cyc=%b we=%b dat=%h sel=%b exp 1 1 a5a5 01",
                  wb_cyc_o, wb_we_o, wb_dat_o, wb_sel_o);
      end
      serve(1, 0, 16'h7777, 1'b1, 16'h0040, 16'hA5A5, 2'b01, stb, bad);
      checks++;
      if (stb !== 1 || bad !== 0 || rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL write_latency got cycles=%0d bad=%0d valid=%b exp 1 0 1", stb, bad, rsp_valid);
      end
      checks++;
      if (rsp_dat !== 16'h0 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL write_rsp got dat=%h err=%b exp 0000 0", rsp_dat, rsp_err);
      end
      consume(0, uns);
   endtask

   task automatic test_timeout;
      int stb, bad, uns;
      logic [15:0] a, d;
      a = 16'($urandom);
      d = 16'($urandom);
      issue(1'b0, a, d, 2'b10);
      serve(0, 0, 16'h0, 1'b0, a, d, 2'b10, stb, bad);
      checks++;
      if (stb !== TO || bad !== 0) begin
         failures++;
         $display("FAIL timeout_cycles got cycles=%0d bad=%0d exp %0d 0", stb, bad, TO);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 16'h0) begin
         failures++;
         $display("FAIL timeout_rsp got valid=%b err=%b dat=%h exp 1 1 0000", rsp_valid, rsp_err, rsp_dat);
      end
      consume(1, uns);
   endtask

   task automatic test_ack_err_hold;
      int stb, bad, uns;
      logic [15:0] a, d;
      a = 16'($urandom);
      d = 16'($urandom);
      issue(1'b0, a, d, 2'b11);
      serve(3, 2, 16'h1357, 1'b0, a, d, 2'b11, stb, bad);
      checks++;
      if (stb !== 3 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 16'h0) begin
         failures++;
         $display("FAIL ack_err_rsp got cycles=%0d valid=%b err=%b dat=%h exp 3 1 1 0000",
                  stb, rsp_valid, rsp_err, rsp_dat);
      end
      consume(5, uns);
      checks++;
      if (uns !== 0) begin
         failures++;
         $display("FAIL hold_stable got unstable_cycles=%0d exp 0", uns);
      end
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_release got ready=%b valid=%b exp 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_reset_mid_bus;
      issue(1'b1, 16'h0BAD, 16'hCAFE, 2'b11);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_bus got cyc=%b stb=%b ready=%b valid=%b exp 0 0 1 0",
                  wb_cyc_o, wb_stb_o, req_ready, rsp_valid);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_rsp got valid=%b cyc=%b exp 0 0", rsp_valid, wb_cyc_o);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 24; i++) begin
         logic        we, exp_err;
         logic [15:0] a, d, rd, exp_dat;
         logic [1:0]  s;
         int          reply, kind, hold, stb, bad, uns, exp_stb;
         we    = 1'($urandom_range(0, 1));
         a     = 16'($urandom);
         d     = 16'($urandom);
         s     = 2'($urandom);
         rd    = 16'($urandom);
         reply = $urandom_range(0, 18);
         kind  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         hold  = $urandom_range(0, 3);
         ref_model(we, reply, kind, rd, exp_stb, exp_err, exp_dat);
         checks++;
         if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready[%0d] got %b exp 1", i, req_ready);
         end
         issue(we, a, d, s);
         serve(reply, kind, rd, we, a, d, s, stb, bad);
         checks++;
         if (stb !== exp_stb || bad !== 0) begin
            failures++;
            $display("FAIL b2b_cycles[%0d] got cycles=%0d bad=%0d exp %0d 0", i, stb, bad, exp_stb);
         end
         checks++;
         if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_dat !== exp_dat) begin
            failures++;
            $display("FAIL b2b_rsp[%0d] got valid=%b err=%b dat=%h exp 1 %b %h",
                     i, rsp_valid, rsp_err, rsp_dat, exp_err, exp_dat);
         end
         consume(hold, uns);
         checks++;
         if (uns !== 0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_consume[%0d] got unstable=%0d valid=%b exp 0 0", i, uns, rsp_valid);
         end
      end
   endtask

   task automatic test_wide;
      logic [15:0] a;
      logic [31:0] d;
      a = 16'($urandom);
      d = $urandom;
      req_valid_w = 1'b1; req_we_w = 1'b0; req_adr_w = a; req_dat_w = d; req_sel_w = 4'b1100;
      @(negedge clk);
      req_valid_w = 1'b0;
      checks++;
      if (wb_cyc_o_w !== 1'b1 || wb_stb_o_w !== 1'b1 || wb_we_o_w !== 1'b0 ||
          wb_sel_o_w !== 4'b1100 || wb_adr_o_w !== a || wb_dat_o_w !== d) begin
         failures++;
         $display("FAIL wide_wb got cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h exp 1 1 0 1100 %h %h",
                  wb_cyc_o_w, wb_stb_o_w, wb_we_o_w, wb_sel_o_w, wb_adr_o_w, wb_dat_o_w, a, d);
      end
      wb_ack_i_w = 1'b1;
      wb_dat_i_w = 32'hDEADBEEF;
      @(negedge clk);
      wb_ack_i_w = 1'b0;
      checks++;
      if (rsp_valid_w !== 1'b1 || rsp_dat_w !== 32'hDEADBEEF || rsp_err_w !== 1'b0) begin
         failures++;
         $display("FAIL wide_rsp got valid=%b dat=%h err=%b exp 1 deadbeef 0",
                  rsp_valid_w, rsp_dat_w, rsp_err_w);
      end
      rsp_ready_w = 1'b1;
      @(negedge clk);
      rsp_ready_w = 1'b0;
      checks++;
      if (req_ready_w !== 1'b1 || rsp_valid_w !== 1'b0) begin
         failures++;
         $display("FAIL wide_done got ready=%b valid=%b exp 1 0", req_ready_w, rsp_valid_w);
      end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
      rsp_ready = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      req_valid_w = 1'b0; req_we_w = 1'b0; req_adr_w = '0; req_dat_w = '0; req_sel_w = '0;
      rsp_ready_w = 1'b0; wb_dat_i_w = '0; wb_ack_i_w = 1'b0; wb_err_i_w = 1'b0;
      @(negedge clk);
      test_reset();
      test_read_wait();
      test_write_zero_wait();
      test_timeout();
      test_ack_err_hold();
      test_reset_mid_bus();
      test_back_to_back();
      test_wide();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
